fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and hazard controller for the MIPS pipeline; sits at the ID/EXE boundary.
- Resolves forwarding one cycle early, in ID, and registers the selects so they are stable for the whole EXE cycle.
- Generalises the original two-operand-plus-store/branch forwarding to NUM_SRC operands.
- Adds load-use hazard detection, a multi-cycle load-latency stall FSM, external freeze handling and a stall performance counter.

Parameters:
- REG_AW, 5, register-address width.
- NUM_SRC, 3, number of source operands (0 = rs, 1 = rt, 2 = store/branch data).
- LOAD_LAT, 1, total stall cycles for a load-use hazard; must be ≥ 1.
- FWD_R0, 0, if 0, register address 0 never matches for forwarding or hazards.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_src  in  NUM_SRC*REG_AW  source addresses; operand i occupies bits [i*REG_AW +: REG_AW]
- id_src_use  in  NUM_SRC  operand i is actually read by the ID instruction
- exe_dest  in  REG_AW  destination of the EXE instruction
- exe_wb  in  1  EXE instruction writes back
- exe_is_load  in  1  EXE instruction is a load
- mem_dest  in  REG_AW  destination of the MEM instruction
- mem_wb  in  1  MEM instruction writes back
- pipe_hold  in  1  external freeze (e.g. memory not ready)
- fwd_sel  out  NUM_SRC*2  registered selects, 2 bits per operand: 0 = regfile, 1 = MEM-stage result, 2 = WB-stage result, 3 = unused
- stall_if_id  out  1  hold PC and the IF/ID register
- bubble_exe  out  1  insert a NOP into ID/EXE
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst = 0, asynchronous): fwd_sel = 0, FSM = IDLE, wait counter = 0, stall_cnt = 0.
- Combinational outputs stall_if_id and bubble_exe are 0 whenever the FSM is IDLE and no hazard exists.
- Per-operand match: m_exe[i] = exe_wb & (id_src[i] == exe_dest) & id_src_use[i] & id_valid. m_mem[i] is defined the same way using mem_wb and mem_dest. When FWD_R0 = 0, the address-0 term forces both to 0.
- Next-cycle select (the EXE instruction will be in MEM, the MEM instruction in WB):
  - m_exe[i] → 1
  - else m_mem[i] → 2
  - else → 0
  - Priority goes to the youngest producer.
- Load-use hazard: haz = exe_is_load & OR over i of m_exe[i].
- FSM states:
  - IDLE:
    - haz = 1 → stall_if_id = 1, bubble_exe = 1 in the same cycle.
    - If LOAD_LAT = 1, stay in IDLE.
    - If LOAD_LAT > 1, go to WAIT with counter = LOAD_LAT - 1.
  - WAIT:
    - stall_if_id = 1, bubble_exe = 1; counter decrements each cycle.
    - Counter = 1 → go to IDLE next cycle.
    - Hazard terms are ignored in WAIT; the load is already past EXE.
- fwd_sel register:
  - Loads the next-cycle select every clock in which pipe_hold = 0.
  - During a stall or bubble it loads 0, because the bubble enters EXE.
  - Counter width is clog2(LOAD_LAT + 1).
- pipe_hold = 1 has priority over everything: fwd_sel, FSM state, counter and stall_cnt all hold their values. stall_if_id and bubble_exe still reflect the current state or hazard.
- stall_cnt increments by 1 on each clock with stall_if_id = 1 and pipe_hold = 0, and saturates at all-ones.
- Operands with id_src_use = 0, or id_valid = 0, never cause forwarding or stalls.
- Several operands matching different stages is allowed: each operand resolves independently.
- Reset asserted mid-WAIT aborts the stall immediately (asynchronous).

Decomposition:
- Shared package/header holds:
  - FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2
  - FSM state encodings IDLE/WAIT
- One natural sub-module, fwd_src_match: a single-operand comparator producing the 2-bit select and a load-hazard bit. Instantiate it NUM_SRC times in a generate loop.

Test Plan:
- Reset: drive rst = 0 with inputs toggling → fwd_sel = 0, stall_if_id = 0, stall_cnt = 0.
- EXE→MEM forward: id_src[0] = 5, exe_dest = 5, exe_wb = 1, exe_is_load = 0 → after the clock, fwd_sel[1:0] = 1 and no stall.
- Priority: id_src[1] = 7, exe_dest = 7, mem_dest = 7, both wb = 1 → fwd_sel[3:2] = 1. Clear exe_wb → 2.
- Load-use, LOAD_LAT = 3: id_src[0] = 9, exe_dest = 9, exe_is_load = 1 → stall_if_id = 1 for exactly 3 cycles, bubble_exe = 1 for those cycles, stall_cnt = 3.
- pipe_hold = 1 asserted during WAIT for 2 cycles → the stall lengthens by 2 cycles, stall_cnt still ends at 3, and fwd_sel is unchanged during the hold.
- Zero register with FWD_R0 = 0: id_src[2] = 0, exe_dest = 0, exe_wb = 1, exe_is_load = 1 → fwd_sel[5:4] = 0 and no stall. The same case with id_src_use[2] = 0 and src = 4, dest = 4 → also no action.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
//   Shared definitions for the ID/EXE forwarding and hazard controller:
//   forwarding-select encodings, stall FSM state encoding, the per-operand
//   match result record and the select priority helper.
// ---------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

  // Operand source selects as seen by the EXE-stage operand muxes.
  localparam logic [1:0] FWD_RF  = 2'd0;  // register file value
  localparam logic [1:0] FWD_MEM = 2'd1;  // result now sitting in MEM
  localparam logic [1:0] FWD_WB  = 2'd2;  // result now sitting in WB

  // Load-latency stall FSM.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Per-operand comparator result.
  typedef struct packed {
    logic [1:0] sel;  // select to use next cycle, when this instruction is in EXE
    logic       haz;  // operand needs the result of a load currently in EXE
  } match_t;

  // Youngest producer wins: the EXE instruction is newer than the MEM one,
  // so its value supersedes an older write to the same register.
  function automatic logic [1:0] fwd_pick(input logic m_exe, input logic m_mem);
    if (m_exe)      return FWD_MEM;
    else if (m_mem) return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// ---------------------------------------------------------------------------
// fwd_src_match
//   Single-operand comparator. Matches one ID source register against the
//   EXE and MEM destinations and produces the forwarding select that will
//   apply one cycle later, plus a load-use hazard bit.
//
// Ports
//   src          in  REG_AW  source register address of this operand
//   src_use      in  1       operand is actually read by the ID instruction
//   id_valid     in  1       ID holds a real instruction
//   exe_dest     in  REG_AW  EXE destination register
//   exe_wb       in  1       EXE instruction writes back
//   exe_is_load  in  1       EXE instruction is a load
//   mem_dest     in  REG_AW  MEM destination register
//   mem_wb       in  1       MEM instruction writes back
//   res          out match_t select + hazard for this operand
// ---------------------------------------------------------------------------
module fwd_src_match
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_R0 = 0
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_use,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb,
  input  logic              exe_is_load,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb,
  output match_t            res
);

  logic rd_ok;   // operand participates at all
  logic r0_ok;   // address is eligible for matching
  logic m_exe;
  logic m_mem;

  // With FWD_R0 = 0 the hardwired zero register never produces a match;
  // checking src alone suffices since a match implies src == dest.
  assign r0_ok = (FWD_R0 != 0) || (src != '0);
  assign rd_ok = id_valid & src_use & r0_ok;

  assign m_exe = rd_ok & exe_wb & (src == exe_dest);
  assign m_mem = rd_ok & mem_wb & (src == mem_dest);

  assign res.sel = fwd_pick(m_exe, m_mem);
  assign res.haz = exe_is_load & m_exe;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding and hazard controller at the ID/EXE boundary. Forwarding is
//   resolved in ID and registered so the selects are stable for the whole
//   EXE cycle. Load-use hazards stall IF/ID and bubble EXE for LOAD_LAT
//   cycles; an external freeze holds every piece of state.
//
// Ports
//   clk          in  1                rising-edge clock
//   rst          in  1                asynchronous active-low reset
//   id_valid     in  1                ID stage holds a real instruction
//   id_src       in  NUM_SRC*REG_AW   operand i at [i*REG_AW +: REG_AW]
//   id_src_use   in  NUM_SRC          operand i is read by the ID instruction
//   exe_dest     in  REG_AW           EXE destination
//   exe_wb       in  1                EXE writes back
//   exe_is_load  in  1                EXE is a load
//   mem_dest     in  REG_AW           MEM destination
//   mem_wb       in  1                MEM writes back
//   pipe_hold    in  1                external freeze
//   fwd_sel      out NUM_SRC*2        registered selects, 2 bits per operand
//   stall_if_id  out 1                hold PC and IF/ID
//   bubble_exe   out 1                insert a NOP into ID/EXE
//   stall_cnt    out CNT_W            saturating hazard-stall cycle count
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 3,
  parameter int LOAD_LAT = 1,
  parameter int FWD_R0   = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_use,
  input  logic [REG_AW-1:0]         exe_dest,
  input  logic                      exe_wb,
  input  logic                      exe_is_load,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic                      mem_wb,
  input  logic                      pipe_hold,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_if_id,
  output logic                      bubble_exe,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  match_t [NUM_SRC-1:0]      mres;
  logic   [NUM_SRC-1:0][1:0] nxt_sel;
  logic   [NUM_SRC-1:0][1:0] sel_q;
  logic   [NUM_SRC-1:0]      haz_vec;
  logic                      haz;

  state_t                    state, state_nxt;
  logic   [CW-1:0]           cnt, cnt_nxt;

  // -------------------------------------------------------------------------
  // Per-operand comparators
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_match #(
      .REG_AW (REG_AW),
      .FWD_R0 (FWD_R0)
    ) u_match (
      .src         (id_src[g*REG_AW +: REG_AW]),
      .src_use     (id_src_use[g]),
      .id_valid    (id_valid),
      .exe_dest    (exe_dest),
      .exe_wb      (exe_wb),
      .exe_is_load (exe_is_load),
      .mem_dest    (mem_dest),
      .mem_wb      (mem_wb),
      .res         (mres[g])
    );
    assign nxt_sel[g] = mres[g].sel;
    assign haz_vec[g] = mres[g].haz;
  end

  assign haz = |haz_vec;

  // -------------------------------------------------------------------------
  // Stall FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (!pipe_hold) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Stall FSM: next state. The IDLE hazard cycle is the first stall cycle,
  // so WAIT covers the remaining LOAD_LAT-1 cycles. In WAIT the load has
  // already left EXE, so hazard terms are not looked at.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (haz && (LOAD_LAT > 1)) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CW'(LOAD_LAT - 1);
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stall FSM: outputs. Still driven during pipe_hold so the rest of the
  // pipeline sees a consistent picture of the current hazard.
  // -------------------------------------------------------------------------
  always_comb begin
    stall_if_id = 1'b0;
    bubble_exe  = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_if_id = haz;
        bubble_exe  = haz;
      end
      ST_WAIT: begin
        stall_if_id = 1'b1;
        bubble_exe  = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered forwarding selects. A stall cycle pushes a bubble into EXE,
  // and a bubble must read the register file, hence the zero load.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            sel_q <= '0;
    else if (!pipe_hold) sel_q <= stall_if_id ? '0 : nxt_sel;
  end

  assign fwd_sel = sel_q;

  // -------------------------------------------------------------------------
  // Saturating stall counter; frozen cycles are not hazard stalls.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_if_id && !pipe_hold && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//   Directed bench with a behavioural reference model. The model tracks the
//   number of stall cycles still owed and the forwarding selects derived
//   straight from the match/priority rules; a per-cycle compare process
//   checks every output against it, and directed steps add literal checks.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 3;
  localparam int LOAD_LAT = 3;
  localparam int FWD_R0   = 0;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_use;
  logic [REG_AW-1:0]         exe_dest;
  logic                      exe_wb;
  logic                      exe_is_load;
  logic [REG_AW-1:0]         mem_dest;
  logic                      mem_wb;
  logic                      pipe_hold;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall_if_id;
  logic                      bubble_exe;
  logic [CNT_W-1:0]          stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .REG_AW   (REG_AW),
    .NUM_SRC  (NUM_SRC),
    .LOAD_LAT (LOAD_LAT),
    .FWD_R0   (FWD_R0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_use  (id_src_use),
    .exe_dest    (exe_dest),
    .exe_wb      (exe_wb),
    .exe_is_load (exe_is_load),
    .mem_dest    (mem_dest),
    .mem_wb      (mem_wb),
    .pipe_hold   (pipe_hold),
    .fwd_sel     (fwd_sel),
    .stall_if_id (stall_if_id),
    .bubble_exe  (bubble_exe),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int m_fwd [NUM_SRC];
  int m_wait = 0;   // stall cycles still owed after the current one
  int m_cnt  = 0;

  function automatic bit hit(input int i, input logic [REG_AW-1:0] dest, input logic wb);
    logic [REG_AW-1:0] a;
    a = id_src[i*REG_AW +: REG_AW];
    return id_valid && id_src_use[i] && wb && (a == dest) && (FWD_R0 != 0 || a != 0);
  endfunction

  function automatic bit m_haz();
    for (int i = 0; i < NUM_SRC; i++)
      if (exe_is_load && hit(i, exe_dest, exe_wb)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return (m_wait > 0) || m_haz();
  endfunction

  function automatic int m_next(input int i);
    if (hit(i, exe_dest, exe_wb)) return 1;
    if (hit(i, mem_dest, mem_wb)) return 2;
    return 0;
  endfunction

  function automatic int m_fwd_flat();
    int v = 0;
    for (int i = 0; i < NUM_SRC; i++) v += m_fwd[i] << (2 * i);
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) m_fwd[i] <= 0;
      m_wait <= 0;
      m_cnt  <= 0;
    end else if (!pipe_hold) begin
      if (m_stall()) begin
        for (int i = 0; i < NUM_SRC; i++) m_fwd[i] <= 0;
        m_wait <= (m_wait > 0) ? m_wait - 1 : LOAD_LAT - 1;
        if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) m_fwd[i] <= m_next(i);
      end
    end
  end

  // Per-cycle compare, mid-cycle.
  always @(negedge clk) begin
    chk("cyc_fwd_sel", int'(fwd_sel), m_fwd_flat());
    chk("cyc_stall",   int'(stall_if_id), int'(m_stall()));
    chk("cyc_bubble",  int'(bubble_exe),  int'(m_stall()));
    chk("cyc_cnt",     int'(stall_cnt),   m_cnt);
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_valid    = 1'b1;
    id_src      = '0;
    id_src_use  = '0;
    exe_dest    = '0;
    exe_wb      = 1'b0;
    exe_is_load = 1'b0;
    mem_dest    = '0;
    mem_wb      = 1'b0;
    pipe_hold   = 1'b0;
  endtask

  task automatic set_src(input int i, input int a);
    id_src[i*REG_AW +: REG_AW] = REG_AW'(a);
  endtask

  initial begin
    int n, nb;
    rst = 1'b0;
    clear();

    // Reset with inputs toggling (no loads, so no hazard)
    for (int k = 0; k < 4; k++) begin
      tick();
      id_src     = 15'($urandom);
      id_src_use = 3'($urandom);
      exe_dest   = id_src[4:0];
      mem_dest   = id_src[9:5];
      exe_wb     = 1'b1;
      mem_wb     = 1'b1;
    end
    #1;
    chk("reset_fwd_sel", int'(fwd_sel), 0);
    chk("reset_stall",   int'(stall_if_id), 0);
    chk("reset_cnt",     int'(stall_cnt), 0);
    rst = 1'b1;
    clear();
    tick();

    // EXE -> MEM forward on operand 0
    clear(); set_src(0, 5); id_src_use = 3'b001; exe_dest = 5; exe_wb = 1'b1;
    #1 chk("exe_fwd_nostall", int'(stall_if_id), 0);
    tick();
    chk("exe_fwd_sel0", int'(fwd_sel[1:0]), 1);

    // Priority: EXE over MEM, then MEM alone
    clear(); set_src(1, 7); id_src_use = 3'b010;
    exe_dest = 7; exe_wb = 1'b1; mem_dest = 7; mem_wb = 1'b1;
    tick();
    chk("prio_exe", int'(fwd_sel[3:2]), 1);
    exe_wb = 1'b0;
    tick();
    chk("prio_mem", int'(fwd_sel[3:2]), 2);

    // Load-use hazard, three stall cycles; load then moves to MEM
    clear(); set_src(0, 9); id_src_use = 3'b001; exe_dest = 9; exe_wb = 1'b1; exe_is_load = 1'b1;
    #1;
    n  = int'(stall_if_id);
    nb = int'(bubble_exe);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        exe_wb = 1'b0; exe_is_load = 1'b0; mem_dest = 9; mem_wb = 1'b1;
      end
      #1;
      n  += int'(stall_if_id);
      nb += int'(bubble_exe);
    end
    chk("ld_stall_cycles",  n, 3);
    chk("ld_bubble_cycles", nb, 3);
    chk("ld_cnt",           int'(stall_cnt), 3);
    chk("ld_after_fwd",     int'(fwd_sel[1:0]), 2);

    // Load-use with a 2-cycle freeze inside WAIT
    clear(); set_src(0, 11); id_src_use = 3'b001; exe_dest = 11; exe_wb = 1'b1; exe_is_load = 1'b1;
    #1;
    n = int'(stall_if_id);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        exe_wb = 1'b0; exe_is_load = 1'b0; pipe_hold = 1'b1;
      end
      if (k == 2) pipe_hold = 1'b0;
      #1;
      n += int'(stall_if_id);
      if (k == 1 || k == 2) chk("hold_fwd_sel", int'(fwd_sel), 0);
    end
    chk("hold_stall_cycles", n, 5);
    chk("hold_cnt",          int'(stall_cnt), 6);

    // Zero register never matches
    clear(); set_src(2, 0); id_src_use = 3'b100; exe_dest = 0; exe_wb = 1'b1; exe_is_load = 1'b1;
    #1 chk("r0_nostall", int'(stall_if_id), 0);
    tick();
    chk("r0_fwd_sel2", int'(fwd_sel[5:4]), 0);
    // Unused operand never matches
    id_src_use = 3'b000; set_src(2, 4); exe_dest = 4;
    #1 chk("unused_nostall", int'(stall_if_id), 0);
    tick();
    chk("unused_fwd_sel2", int'(fwd_sel[5:4]), 0);
    chk("r0_cnt_kept",     int'(stall_cnt), 6);

    // id_valid = 0 never matches
    clear(); id_valid = 1'b0; set_src(0, 5); id_src_use = 3'b001; exe_dest = 5; exe_wb = 1'b1; exe_is_load = 1'b1;
    #1 chk("invalid_nostall", int'(stall_if_id), 0);
    tick();
    chk("invalid_fwd_sel", int'(fwd_sel), 0);

    // Independent resolution: op0 <- EXE, op1 <- MEM, op2 <- EXE
    clear(); set_src(0, 3); set_src(1, 4); set_src(2, 3); id_src_use = 3'b111;
    exe_dest = 3; exe_wb = 1'b1; mem_dest = 4; mem_wb = 1'b1;
    tick();
    chk("multi_fwd_sel", int'(fwd_sel), 6'b01_10_01);

    // Asynchronous reset in the middle of WAIT
    clear(); set_src(0, 9); id_src_use = 3'b001; exe_dest = 9; exe_wb = 1'b1; exe_is_load = 1'b1;
    tick();
    exe_wb = 1'b0; exe_is_load = 1'b0;
    #1 chk("midwait_stall", int'(stall_if_id), 1);
    #1 rst = 1'b0;
    #1;
    chk("midwait_rst_stall", int'(stall_if_id), 0);
    chk("midwait_rst_cnt",   int'(stall_cnt), 0);
    tick();
    rst = 1'b1;

    // Back-to-back load-use hazards saturate the counter
    clear(); set_src(1, 12); id_src_use = 3'b010; exe_dest = 12; exe_wb = 1'b1; exe_is_load = 1'b1;
    repeat (20) tick();
    chk("sat_stall", int'(stall_if_id), 1);
    chk("sat_cnt",   int'(stall_cnt), CNT_MAX);

    clear();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
